count_sequencer: RTL and testbench

Run controller for the lab's 3-bit synchronous counter datapath. It accepts a start command with a terminal value, sequences the counter's clear and enable from 0 up to the terminal, and supports pause, abort and auto-repeat. It reports busy, a one-cycle done pulse and a saturating completed-run tally. It sits between the lab's switch/debounce front end and the counter/display outputs.

---
 rtl/count_seq_pkg.sv | 20 ++
 rtl/mod_counter.sv | 22 ++
 rtl/count_sequencer.sv | 105 ++++++++++
 tb/tb_count_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and helpers for the count_sequencer run controller.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    localparam int COUNT_W = 3;
    localparam int RUNS_W  = 4;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] value,
        input logic [31:0] limit
    );
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// WIDTH-bit counter register with synchronous zero-load and count enable.
module mod_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load_zero,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (!clear) begin
            count <= '0;
        end else if (load_zero) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Run controller: sequences the counter from 0 to a captured terminal value,
// with pause, abort, auto-repeat, a done pulse and a saturating run tally.
module count_sequencer #(
    parameter int WIDTH  = count_seq_pkg::COUNT_W,
    parameter int RUNS_W = count_seq_pkg::RUNS_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [WIDTH-1:0]  terminal,
    input  logic              repeat_en,
    input  logic              pause,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [RUNS_W-1:0] runs
);

    import count_seq_pkg::*;

    localparam logic [31:0] RUNS_MAX = (32'd1 << RUNS_W) - 32'd1;

    state_t           state;
    logic [WIDTH-1:0] term_q;
    logic             rep_q;
    logic             hit;
    logic             stepping;
    logic             load_zero;
    logic             enable;

    assign hit      = (count == term_q);
    assign stepping = (state == RUN) && !pause;

    // Counter control mirrors the FSM decisions taken on the same edge.
    always_comb begin
        load_zero = 1'b0;
        enable    = 1'b0;
        if (abort) begin
            load_zero = 1'b1;
        end else if (state == IDLE) begin
            load_zero = start;
        end else if (stepping) begin
            load_zero = hit && rep_q;
            enable    = !hit;
        end
    end

    mod_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clock    (clock),
        .clear    (clear),
        .load_zero(load_zero),
        .enable   (enable),
        .count    (count)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!clear) begin
            state  <= IDLE;
            term_q <= '0;
            rep_q  <= 1'b0;
            done   <= 1'b0;
            runs   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                rep_q <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            term_q <= terminal;
                            rep_q  <= repeat_en;
                            runs   <= '0;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state <= HOLD;
                        end else if (hit) begin
                            done <= 1'b1;
                            runs <= RUNS_W'(sat_inc(32'(runs), RUNS_MAX));
                            if (!rep_q) begin
                                state <= IDLE;
                            end
                        end
                    end
                    HOLD: begin
                        if (!pause) begin
                            state <= RUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer.
module tb_count_sequencer;

    logic       clock;
    logic       clear;
    logic       start;
    logic [2:0] terminal;
    logic       repeat_en;
    logic       pause;
    logic       abort;
    logic [2:0] count;
    logic       busy;
    logic       done;
    logic [3:0] runs;

    int vecs;
    int errs;

    count_sequencer dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .terminal (terminal),
        .repeat_en(repeat_en),
        .pause    (pause),
        .abort    (abort),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .runs     (runs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        start = 1'b0;
        terminal = 3'd0;
        repeat_en = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        step();
        step();
        vecs++;
        if ({count, busy, done, runs} !== {3'd0, 1'b0, 1'b0, 4'd0}) begin
            errs++;
            $display("FAIL reset: count=%0d busy=%b done=%b runs=%0d want 0/0/0/0",
                     count, busy, done, runs);
        end
        clear = 1'b1;
        step();
        vecs++;
        if ({count, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_idle: count=%0d busy=%b done=%b want 0/0/0",
                     count, busy, done);
        end
    endtask

    task automatic test_oneshot();
        terminal = 3'd5;
        repeat_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        vecs++;
        if ({count, busy, done, runs} !== {3'd0, 1'b1, 1'b0, 4'd0}) begin
            errs++;
            $display("FAIL oneshot_start: count=%0d busy=%b done=%b runs=%0d want 0/1/0/0",
                     count, busy, done, runs);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            vecs++;
            if ({count, busy, done} !== {3'(i), 1'b1, 1'b0}) begin
                errs++;
                $display("FAIL oneshot_step%0d: count=%0d busy=%b done=%b want %0d/1/0",
                         i, count, busy, done, i);
            end
        end
        step();
        vecs++;
        if ({count, busy, done, runs} !== {3'd5, 1'b0, 1'b1, 4'd1}) begin
            errs++;
            $display("FAIL oneshot_done: count=%0d busy=%b done=%b runs=%0d want 5/0/1/1",
                     count, busy, done, runs);
        end
        step();
        vecs++;
        if ({count, busy, done, runs} !== {3'd5, 1'b0, 1'b0, 4'd1}) begin
            errs++;
            $display("FAIL oneshot_after: count=%0d busy=%b done=%b runs=%0d want 5/0/0/1",
                     count, busy, done, runs);
        end
    endtask

    task automatic test_repeat();
        terminal = 3'd3;
        repeat_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        vecs++;
        if ({count, busy, runs} !== {3'd0, 1'b1, 4'd0}) begin
            errs++;
            $display("FAIL repeat_start: count=%0d busy=%b runs=%0d want 0/1/0",
                     count, busy, runs);
        end
        for (int e = 1; e <= 20; e++) begin
            // A new terminal and a start while busy must both be ignored.
            if (e == 2) begin
                terminal = 3'd7;
                start = 1'b1;
            end
            if (e == 3) start = 1'b0;
            step();
            vecs++;
            if ({count, done, runs, busy} !==
                {3'(e % 4), (e % 4) == 0, 4'(e / 4), 1'b1}) begin
                errs++;
                $display("FAIL repeat_e%0d: count=%0d done=%b runs=%0d busy=%b want %0d/%b/%0d/1",
                         e, count, done, runs, busy, e % 4, (e % 4) == 0, e / 4);
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vecs++;
        if ({count, busy, done, runs} !== {3'd0, 1'b0, 1'b0, 4'd5}) begin
            errs++;
            $display("FAIL repeat_abort: count=%0d busy=%b done=%b runs=%0d want 0/0/0/5",
                     count, busy, done, runs);
        end
    endtask

    task automatic test_pause();
        int dones;
        int done_edge;
        logic [2:0] exp_count [1:10];
        exp_count = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};
        dones = 0;
        done_edge = 0;
        terminal = 3'd6;
        repeat_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        // Pause sampled high on edges k+3 and k+4 (RUN->HOLD, stay),
        // HOLD->RUN at k+5: three edges without a step.
        for (int e = 1; e <= 12; e++) begin
            pause = (e == 3 || e == 4);
            step();
            if (done) begin
                dones++;
                done_edge = e;
            end
            if (e <= 10) begin
                vecs++;
                if (count !== exp_count[e]) begin
                    errs++;
                    $display("FAIL pause_e%0d: count=%0d want %0d", e, count, exp_count[e]);
                end
            end
        end
        pause = 1'b0;
        vecs++;
        if (dones !== 1 || done_edge !== 10) begin
            errs++;
            $display("FAIL pause_done: dones=%0d at edge %0d want 1 at edge 10",
                     dones, done_edge);
        end
        vecs++;
        if ({busy, runs} !== {1'b0, 4'd1}) begin
            errs++;
            $display("FAIL pause_end: busy=%b runs=%0d want 0/1", busy, runs);
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        terminal = 3'd7;
        repeat_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        vecs++;
        if (count !== 3'd4) begin
            errs++;
            $display("FAIL abort_pre: count=%0d want 4", count);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        if (done) dones++;
        vecs++;
        if ({count, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL abort_edge: count=%0d busy=%b done=%b want 0/0/0",
                     count, busy, done);
        end
        for (int e = 0; e < 8; e++) begin
            step();
            if (done) dones++;
        end
        vecs++;
        if (dones !== 0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL abort_nodone: dones=%0d busy=%b want 0/0", dones, busy);
        end
        terminal = 3'd2;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        vecs++;
        if ({count, busy, runs} !== {3'd0, 1'b0, 4'd0}) begin
            errs++;
            $display("FAIL abort_start: count=%0d busy=%b runs=%0d want 0/0/0",
                     count, busy, runs);
        end
        step();
        vecs++;
        if ({count, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL abort_start_idle: count=%0d busy=%b done=%b want 0/0/0",
                     count, busy, done);
        end
    endtask

    task automatic test_term_zero();
        terminal = 3'd0;
        repeat_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        vecs++;
        if ({count, busy, done} !== {3'd0, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL zero_start: count=%0d busy=%b done=%b want 0/1/0",
                     count, busy, done);
        end
        step();
        vecs++;
        if ({count, busy, done, runs} !== {3'd0, 1'b0, 1'b1, 4'd1}) begin
            errs++;
            $display("FAIL zero_oneshot: count=%0d busy=%b done=%b runs=%0d want 0/0/1/1",
                     count, busy, done, runs);
        end
        repeat_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        vecs++;
        if ({busy, done, runs} !== {1'b1, 1'b0, 4'd0}) begin
            errs++;
            $display("FAIL zero_rep_start: busy=%b done=%b runs=%0d want 1/0/0",
                     busy, done, runs);
        end
        for (int e = 1; e <= 20; e++) begin
            step();
            vecs++;
            if ({count, done, runs} !== {3'd0, 1'b1, 4'((e > 15) ? 15 : e)}) begin
                errs++;
                $display("FAIL zero_rep_e%0d: count=%0d done=%b runs=%0d want 0/1/%0d",
                         e, count, done, runs, (e > 15) ? 15 : e);
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vecs++;
        if ({busy, done, runs} !== {1'b0, 1'b0, 4'd15}) begin
            errs++;
            $display("FAIL zero_abort: busy=%b done=%b runs=%0d want 0/0/15",
                     busy, done, runs);
        end
    endtask

    task automatic test_clear();
        terminal = 3'd3;
        repeat_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 7; e++) step();
        vecs++;
        if ({count, runs, busy} !== {3'd3, 4'd1, 1'b1}) begin
            errs++;
            $display("FAIL clear_pre: count=%0d runs=%0d busy=%b want 3/1/1",
                     count, runs, busy);
        end
        clear = 1'b0;
        start = 1'b1;
        step();
        clear = 1'b1;
        start = 1'b0;
        vecs++;
        if ({count, busy, done, runs} !== {3'd0, 1'b0, 1'b0, 4'd0}) begin
            errs++;
            $display("FAIL clear_edge: count=%0d busy=%b done=%b runs=%0d want 0/0/0/0",
                     count, busy, done, runs);
        end
        step();
        vecs++;
        if ({count, busy} !== {3'd0, 1'b0}) begin
            errs++;
            $display("FAIL clear_idle: count=%0d busy=%b want 0/0", count, busy);
        end
        terminal = 3'd2;
        repeat_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            vecs++;
            if ({count, done, busy} !==
                {3'((e > 2) ? 2 : e), e == 3, e != 3}) begin
                errs++;
                $display("FAIL restart_e%0d: count=%0d done=%b busy=%b want %0d/%b/%b",
                         e, count, done, busy, (e > 2) ? 2 : e, e == 3, e != 3);
            end
        end
        vecs++;
        if (runs !== 4'd1) begin
            errs++;
            $display("FAIL restart_runs: runs=%0d want 1", runs);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_oneshot();
        test_repeat();
        test_pause();
        test_abort();
        test_term_zero();
        test_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
